// File: rtl/cdc_pkg.sv
// Shared helpers for the multi-channel synchroniser/debouncer.
// Holds the debounce counter width function and the parameter legality
// predicates that each channel checks at elaboration.
package cdc_pkg;

   localparam int SYNC_MIN  = 2;
   localparam int SYNC_MAX  = 4;
   localparam int DEB_MIN   = 1;
   localparam int DEB_MAX   = 255;
   localparam int DELAY_MIN = 2;
   localparam int DELAY_MAX = 8;

   // Width of a counter that must hold values 0..debounce.
   function automatic int cnt_width(input int debounce);
      return (debounce < 1) ? 1 : $clog2(debounce + 1);
   endfunction

   function automatic bit sync_legal(input int syncStages);
      return (syncStages >= SYNC_MIN) && (syncStages <= SYNC_MAX);
   endfunction

   function automatic bit debounce_legal(input int debounce);
      return (debounce >= DEB_MIN) && (debounce <= DEB_MAX);
   endfunction

   function automatic bit delay_legal(input int delayStages);
      return (delayStages >= DELAY_MIN) && (delayStages <= DELAY_MAX);
   endfunction

endpackage

// File: rtl/cdc_channel.sv
// One channel: flop synchroniser, counter debouncer, output delay line,
// edge pulses, sticky edge flags with clear, and a rejected-bounce pulse.
// Every output is driven from registers only, so no path exists from sig_i.
module cdc_channel
   import cdc_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int DEBOUNCE     = 3,
   parameter int DELAY_STAGES = 3,
   parameter bit RESET_VAL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   input  logic evClr_i,
   output logic level_o,
   output logic levelN_o,
   output logic rise_o,
   output logic fall_o,
   output logic evRise_o,
   output logic evFall_o,
   output logic glitch_o
);

   localparam int CW = cnt_width(DEBOUNCE);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   if (!sync_legal(SYNC_STAGES)) begin : gSyncCheck
      $error("cdc_channel: SYNC_STAGES must be 2..4");
   end
   if (!debounce_legal(DEBOUNCE)) begin : gDebCheck
      $error("cdc_channel: DEBOUNCE must be 1..255");
   end
   if (!delay_legal(DELAY_STAGES)) begin : gDelayCheck
      $error("cdc_channel: DELAY_STAGES must be 2..8");
   end

   logic [SYNC_STAGES-1:0]  sync_q, sync_d;
   logic                    stable_q, stable_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    glitch_q, glitch_d;
   logic [DELAY_STAGES-1:0] line_q, line_d;
   logic                    evRise_q, evRise_d;
   logic                    evFall_q, evFall_d;
   logic                    sample;
   logic                    lineTail;
   logic                    linePrev;

   assign sample   = sync_q[SYNC_STAGES-1];
   assign lineTail = line_q[DELAY_STAGES-1];
   assign linePrev = line_q[DELAY_STAGES-2];

   // Shift chains: the synchroniser takes the raw input, the delay line takes the debounced level.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], sig_i};
      line_d = {line_q[DELAY_STAGES-2:0], stable_q};
   end

   // Debouncer: a disagreeing sample must persist DEBOUNCE times to flip; a short run raises glitch.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      glitch_d = 1'b0;
      if (sample != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sample;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (cnt_q != '0) begin
         cnt_d    = '0;
         glitch_d = 1'b1;
      end
   end

   // Sticky flags: a clear drops the flag unless a fresh edge arrives in the same cycle.
   always_comb begin
      evRise_d = (evRise_q & ~evClr_i) | rise_o;
      evFall_d = (evFall_q & ~evClr_i) | fall_o;
   end

   // State register with synchronous reset that overrides clears and edges alike.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= {SYNC_STAGES{RESET_VAL}};
         stable_q <= RESET_VAL;
         cnt_q    <= '0;
         glitch_q <= 1'b0;
         line_q   <= {DELAY_STAGES{RESET_VAL}};
         evRise_q <= 1'b0;
         evFall_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         glitch_q <= glitch_d;
         line_q   <= line_d;
         evRise_q <= evRise_d;
         evFall_q <= evFall_d;
      end
   end

   assign level_o  = lineTail;
   assign levelN_o = ~lineTail;
   assign rise_o   = ~lineTail & linePrev;
   assign fall_o   = lineTail & ~linePrev;
   assign evRise_o = evRise_q;
   assign evFall_o = evFall_q;
   assign glitch_o = glitch_q;

endmodule

// File: rtl/cdc_multi.sv
// Multi-channel synchroniser/debouncer for slow asynchronous inputs
// entering the clk domain. Channels are fully independent instances.
module cdc_multi
   import cdc_pkg::*;
#(
   parameter int               WIDTH        = 1,
   parameter int               SYNC_STAGES  = 2,
   parameter int               DEBOUNCE     = 3,
   parameter int               DELAY_STAGES = 3,
   parameter logic [WIDTH-1:0] RESET_VAL    = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i,
   output logic [WIDTH-1:0] o,
   output logic [WIDTH-1:0] o_n,
   output logic [WIDTH-1:0] o_posedge,
   output logic [WIDTH-1:0] o_negedge,
   output logic [WIDTH-1:0] ev_rise,
   output logic [WIDTH-1:0] ev_fall,
   input  logic [WIDTH-1:0] ev_clr,
   output logic [WIDTH-1:0] glitch
);

   if (WIDTH < 1) begin : gWidthCheck
      $error("cdc_multi: WIDTH must be at least 1");
   end

   for (genvar ch = 0; ch < WIDTH; ch++) begin : gChannel
      cdc_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE    (DEBOUNCE),
         .DELAY_STAGES(DELAY_STAGES),
         .RESET_VAL   (RESET_VAL[ch])
      ) uChannel (
         .clk     (clk),
         .rst     (rst),
         .sig_i   (i[ch]),
         .evClr_i (ev_clr[ch]),
         .level_o (o[ch]),
         .levelN_o(o_n[ch]),
         .rise_o  (o_posedge[ch]),
         .fall_o  (o_negedge[ch]),
         .evRise_o(ev_rise[ch]),
         .evFall_o(ev_fall[ch]),
         .glitch_o(glitch[ch])
      );
   end

endmodule

// File: tb/tb_cdc_multi.sv
// Bench for cdc_multi: instance A uses default timing with RESET_VAL=1010,
// instance B uses SYNC_STAGES=3, DEBOUNCE=1, DELAY_STAGES=2.
// A behavioural model built from delay queues and run lengths predicts every output.
module tb_cdc_multi;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] iA = '0, iB = '0, clrA = '0, clrB = '0;
   logic [W-1:0] oA, onA, posA, negA, evRA, evFA, gltA;
   logic [W-1:0] oB, onB, posB, negB, evRB, evFB, gltB;

   int testsRun    = 0;
   int testsFailed = 0;

   int           syncN[2];
   int           debN[2];
   int           delN[2];
   logic [W-1:0] rvN[2];

   bit inQ[2][W][$];
   bit hist[2][W][$];
   bit stab[2][W];
   int run[2][W];
   bit evR[2][W];
   bit evF[2][W];
   bit glt[2][W];

   always #5 clk = ~clk;

   cdc_multi #(
      .WIDTH(W), .SYNC_STAGES(2), .DEBOUNCE(3), .DELAY_STAGES(3), .RESET_VAL(4'b1010)
   ) dutA (
      .clk(clk), .rst(rst), .i(iA), .o(oA), .o_n(onA), .o_posedge(posA), .o_negedge(negA),
      .ev_rise(evRA), .ev_fall(evFA), .ev_clr(clrA), .glitch(gltA)
   );

   cdc_multi #(
      .WIDTH(W), .SYNC_STAGES(3), .DEBOUNCE(1), .DELAY_STAGES(2), .RESET_VAL(4'b0000)
   ) dutB (
      .clk(clk), .rst(rst), .i(iB), .o(oB), .o_n(onB), .o_posedge(posB), .o_negedge(negB),
      .ev_rise(evRB), .ev_fall(evFB), .ev_clr(clrB), .glitch(gltB)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelResetCh(input int n, input int c);
      inQ[n][c].delete();
      hist[n][c].delete();
      repeat (syncN[n]) inQ[n][c].push_back(rvN[n][c]);
      repeat (delN[n] + 1) hist[n][c].push_back(rvN[n][c]);
      stab[n][c] = rvN[n][c];
      run[n][c]  = 0;
      evR[n][c]  = 1'b0;
      evF[n][c]  = 1'b0;
      glt[n][c]  = 1'b0;
   endtask

   // One clock edge of the reference: input seen SYNC edges late, level flips after a long
   // enough disagreeing run, output is the level DELAY edges late.
   task automatic modelEdge();
      logic [W-1:0] inV, clrV;
      bit s, prePos, preNeg;
      for (int n = 0; n < 2; n++) begin
         inV  = (n == 0) ? iA : iB;
         clrV = (n == 0) ? clrA : clrB;
         for (int c = 0; c < W; c++) begin
            if (rst) begin
               modelResetCh(n, c);
            end else begin
               prePos = !hist[n][c][0] && hist[n][c][1];
               preNeg = hist[n][c][0] && !hist[n][c][1];
               s = inQ[n][c].pop_front();
               inQ[n][c].push_back(inV[c]);
               glt[n][c] = 1'b0;
               if (s != stab[n][c]) begin
                  run[n][c]++;
                  if (run[n][c] >= debN[n]) begin
                     stab[n][c] = s;
                     run[n][c]  = 0;
                  end
               end else begin
                  glt[n][c] = (run[n][c] != 0);
                  run[n][c] = 0;
               end
               hist[n][c].push_back(stab[n][c]);
               void'(hist[n][c].pop_front());
               evR[n][c] = (evR[n][c] && !clrV[c]) || prePos;
               evF[n][c] = (evF[n][c] && !clrV[c]) || preNeg;
            end
         end
      end
   endtask

   function automatic logic [W-1:0] expVec(input int n, input int kind);
      logic [W-1:0] v;
      bit t, p;
      v = '0;
      for (int c = 0; c < W; c++) begin
         t = hist[n][c][0];
         p = hist[n][c][1];
         case (kind)
            0:       v[c] = t;
            1:       v[c] = !t;
            2:       v[c] = !t && p;
            3:       v[c] = t && !p;
            4:       v[c] = evR[n][c];
            5:       v[c] = evF[n][c];
            default: v[c] = glt[n][c];
         endcase
      end
      return v;
   endfunction

   task automatic compareAll();
      checkOutput("A.o",       32'(oA),   32'(expVec(0, 0)));
      checkOutput("A.o_n",     32'(onA),  32'(expVec(0, 1)));
      checkOutput("A.posedge", 32'(posA), 32'(expVec(0, 2)));
      checkOutput("A.negedge", 32'(negA), 32'(expVec(0, 3)));
      checkOutput("A.ev_rise", 32'(evRA), 32'(expVec(0, 4)));
      checkOutput("A.ev_fall", 32'(evFA), 32'(expVec(0, 5)));
      checkOutput("A.glitch",  32'(gltA), 32'(expVec(0, 6)));
      checkOutput("B.o",       32'(oB),   32'(expVec(1, 0)));
      checkOutput("B.o_n",     32'(onB),  32'(expVec(1, 1)));
      checkOutput("B.posedge", 32'(posB), 32'(expVec(1, 2)));
      checkOutput("B.negedge", 32'(negB), 32'(expVec(1, 3)));
      checkOutput("B.ev_rise", 32'(evRB), 32'(expVec(1, 4)));
      checkOutput("B.ev_fall", 32'(evFB), 32'(expVec(1, 5)));
      checkOutput("B.glitch",  32'(gltB), 32'(expVec(1, 6)));
   endtask

   task automatic stepCycle();
      @(posedge clk);
      modelEdge();
      #1;
      compareAll();
   endtask

   task automatic applyStimulus(input logic rstV, input logic [W-1:0] iAV, input logic [W-1:0] iBV,
                                input logic [W-1:0] clrAV, input logic [W-1:0] clrBV);
      rst  = rstV;
      iA   = iAV;
      iB   = iBV;
      clrA = clrAV;
      clrB = clrBV;
      stepCycle();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int latA, latB, posCyc, glitchCnt, oChg, glitchBCnt;
      logic [W-1:0] rA, rB, cA, cB;
      logic rR;

      syncN[0] = 2; debN[0] = 3; delN[0] = 3; rvN[0] = 4'b1010;
      syncN[1] = 3; debN[1] = 1; delN[1] = 2; rvN[1] = 4'b0000;

      // Reset with inputs already at the reset value: outputs settle to RESET_VAL.
      repeat (3) applyStimulus(1'b1, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
      checkOutput("reset.oA",  32'(oA),  32'(4'b1010));
      checkOutput("reset.onA", 32'(onA), 32'(4'b0101));
      checkOutput("reset.oB",  32'(oB),  32'(4'b0000));
      repeat (12) applyStimulus(1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000);

      // Clean rise on channel 0 of both instances; measure latency.
      latA = 0; latB = 0; posCyc = 0;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b0, 4'b1011, 4'b0001, 4'b0000, 4'b0000);
         if (posA[0] && posCyc == 0) posCyc = k;
         if (oA[0] && latA == 0) latA = k;
         if (oB[0] && latB == 0) latB = k;
      end
      checkOutput("latency.A", 32'(latA), 32'd8);
      checkOutput("posedge.A.cycle", 32'(posCyc), 32'd7);
      checkOutput("latency.B", 32'(latB), 32'd6);
      checkOutput("indep.oA", 32'(oA), 32'(4'b1011));
      checkOutput("indep.evRA", 32'(evRA), 32'(4'b0001));

      // Clear the sticky rise flag.
      applyStimulus(1'b0, 4'b1011, 4'b0001, 4'b0001, 4'b0001);
      checkOutput("clr.evRA0", 32'(evRA[0]), 32'd0);
      applyStimulus(1'b0, 4'b1011, 4'b0001, 4'b0000, 4'b0000);

      // Bounce on channel 2: two disagreeing samples, then back.
      glitchCnt = 0; oChg = 0;
      for (int k = 0; k < 14; k++) begin
         applyStimulus(1'b0, (k < 2) ? 4'b1111 : 4'b1011, 4'b0001, 4'b0000, 4'b0000);
         if (gltA[2]) glitchCnt++;
         if (oA[2] || posA[2] || evRA[2]) oChg++;
      end
      checkOutput("bounce.glitches", 32'(glitchCnt), 32'd1);
      checkOutput("bounce.noedge", 32'(oChg), 32'd0);

      // Fall on channel 0 with a clear landing on the falling-edge pulse cycle.
      repeat (7) applyStimulus(1'b0, 4'b1010, 4'b0001, 4'b0000, 4'b0000);
      checkOutput("fall.negedge", 32'(negA[0]), 32'd1);
      applyStimulus(1'b0, 4'b1010, 4'b0001, 4'b0001, 4'b0000);
      checkOutput("fall.evFA0", 32'(evFA[0]), 32'd1);
      checkOutput("fall.evRA0", 32'(evRA[0]), 32'd0);
      repeat (4) applyStimulus(1'b0, 4'b1010, 4'b0001, 4'b0000, 4'b0000);

      // Reset while channel 2 is mid-count on a pending rise.
      repeat (4) applyStimulus(1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
      applyStimulus(1'b1, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
      checkOutput("rstmid.oA", 32'(oA), 32'(4'b1010));
      checkOutput("rstmid.evA", 32'({evRA, evFA}), 32'd0);
      latA = 0; glitchCnt = 0;
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b0, 4'b1110, 4'b0001, 4'b0000, 4'b0000);
         if (gltA[2]) glitchCnt++;
         if (oA[2] && latA == 0) latA = k;
      end
      checkOutput("rstmid.latency", 32'(latA), 32'd8);
      checkOutput("rstmid.noglitch", 32'(glitchCnt), 32'd0);

      // Random bouncing inputs, occasional clears and resets.
      rA = 4'b1110; rB = 4'b0001; glitchBCnt = 0;
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < W; c++) begin
            if ($urandom_range(0, 3) == 0) rA[c] = ~rA[c];
            if ($urandom_range(0, 3) == 0) rB[c] = ~rB[c];
            cA[c] = ($urandom_range(0, 7) == 0);
            cB[c] = ($urandom_range(0, 7) == 0);
         end
         rR = ($urandom_range(0, 149) == 0);
         applyStimulus(rR, rA, rB, cA, cB);
         if (gltB != '0) glitchBCnt++;
      end
      checkOutput("sweep.B.noglitch", 32'(glitchBCnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
